// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the Goldcrest RV32I core: valid/ready capture, operand forwarding and load-use bubble.
// Define OPERAND_FWD_EN to enable EX/MEM and MEM/WB forwarding plus load-use stalling; otherwise operands come straight from the register file.
module id_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic [4:0]      in_rs1,
   input  logic [4:0]      in_rs2,
   input  logic [4:0]      in_rd,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7_5,
   input  logic            in_is_rtype,
   input  logic            in_use_imm,
   input  logic            in_use_pc,
   input  logic            in_is_branch,
   input  logic            in_is_load,
   input  logic            in_reg_write,
   input  logic [4:0]      exmem_rd,
   input  logic [4:0]      memwb_rd,
   input  logic            exmem_wen,
   input  logic            memwb_wen,
   input  logic            exmem_is_load,
   input  logic [XLEN-1:0] exmem_result,
   input  logic [XLEN-1:0] memwb_result,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [XLEN-1:0] store_data,
   output logic [2:0]      alu_select,
   output logic            alu_func7,
   output logic [4:0]      out_rd,
   output logic            out_reg_write,
   output logic            out_is_load
);

   typedef enum logic [1:0] {EMPTY, FULL, LOAD_STALL} state_t;

   state_t          state;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] imm_q;
   logic [XLEN-1:0] rs1v_q;
   logic            use_pc_q;
   logic            use_imm_q;
   logic            haz1_q;
   logic            haz2_q;

   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic            haz1;
   logic            haz2;
   logic            capture;

   assign in_ready = (state == EMPTY) | ((state == FULL) & out_ready);
   assign capture  = in_valid & in_ready & ~flush;

`ifdef OPERAND_FWD_EN
   // A load still in EX/MEM has no data yet, so it is never forwarded from there; that case becomes a bubble.
   always_comb begin
      rs1_fwd = in_rs1_data;
      rs2_fwd = in_rs2_data;
      if ((in_rs1 != 5'd0) && exmem_wen && (exmem_rd == in_rs1) && !exmem_is_load)
         rs1_fwd = exmem_result;
      else if ((in_rs1 != 5'd0) && memwb_wen && (memwb_rd == in_rs1))
         rs1_fwd = memwb_result;
      if ((in_rs2 != 5'd0) && exmem_wen && (exmem_rd == in_rs2) && !exmem_is_load)
         rs2_fwd = exmem_result;
      else if ((in_rs2 != 5'd0) && memwb_wen && (memwb_rd == in_rs2))
         rs2_fwd = memwb_result;
   end

   assign haz1 = (in_rs1 != 5'd0) & exmem_wen & exmem_is_load & (exmem_rd == in_rs1);
   assign haz2 = (in_rs2 != 5'd0) & exmem_wen & exmem_is_load & (exmem_rd == in_rs2);
`else
   logic unused_fwd;

   assign rs1_fwd    = in_rs1_data;
   assign rs2_fwd    = in_rs2_data;
   assign haz1       = 1'b0;
   assign haz2       = 1'b0;
   assign unused_fwd = ^{in_rs1, in_rs2, exmem_rd, memwb_rd, exmem_wen, memwb_wen,
                         exmem_is_load, exmem_result, memwb_result};
`endif

   // Flush beats the stall resolve, which beats a new capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= EMPTY;
         out_valid     <= 1'b0;
         pc_q          <= '0;
         imm_q         <= '0;
         rs1v_q        <= '0;
         use_pc_q      <= 1'b0;
         use_imm_q     <= 1'b0;
         haz1_q        <= 1'b0;
         haz2_q        <= 1'b0;
         alu_a         <= '0;
         alu_b         <= '0;
         store_data    <= '0;
         alu_select    <= 3'b000;
         alu_func7     <= 1'b0;
         out_rd        <= 5'd0;
         out_reg_write <= 1'b0;
         out_is_load   <= 1'b0;
      end else if (flush) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         haz1_q    <= 1'b0;
         haz2_q    <= 1'b0;
      end else if (state == LOAD_STALL) begin
         if (haz1_q) begin
            rs1v_q <= memwb_result;
            if (!use_pc_q)
               alu_a <= memwb_result;
         end
         if (haz2_q) begin
            store_data <= memwb_result;
            if (!use_imm_q)
               alu_b <= memwb_result;
         end
         haz1_q    <= 1'b0;
         haz2_q    <= 1'b0;
         state     <= FULL;
         out_valid <= 1'b1;
      end else if (capture) begin
         pc_q          <= in_pc;
         imm_q         <= in_imm;
         rs1v_q        <= rs1_fwd;
         use_pc_q      <= in_use_pc;
         use_imm_q     <= in_use_imm;
         haz1_q        <= haz1;
         haz2_q        <= haz2;
         alu_a         <= in_use_pc ? in_pc : rs1_fwd;
         alu_b         <= in_use_imm ? in_imm : rs2_fwd;
         store_data    <= rs2_fwd;
         alu_select    <= in_is_branch ? 3'b000 : in_funct3;
         alu_func7     <= in_is_branch ? 1'b1 : (in_is_rtype & in_funct7_5);
         out_rd        <= in_rd;
         out_reg_write <= in_reg_write;
         out_is_load   <= in_is_load;
         state         <= (haz1 | haz2) ? LOAD_STALL : FULL;
         out_valid     <= ~(haz1 | haz2);
      end else if ((state == FULL) && out_ready) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random traffic against a behavioural model.
// Follows the OPERAND_FWD_EN setting of the build so it can check either configuration.
module tb_id_ex_stage;

`ifdef OPERAND_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [2:0]  in_funct3;
   logic        in_funct7_5, in_is_rtype, in_use_imm, in_use_pc, in_is_branch, in_is_load, in_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_wen, memwb_wen, exmem_is_load;
   logic [31:0] exmem_result, memwb_result;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_a, alu_b, store_data;
   logic [2:0]  alu_select;
   logic        alu_func7;
   logic [4:0]  out_rd;
   logic        out_reg_write, out_is_load;

   int checks;
   int failures;

   // Model of the held instruction: raw operand values plus decode fields.
   bit          m_valid, m_bubble, m_zeroed, m_hz1, m_hz2;
   logic [31:0] m_pc, m_imm, m_rs1v, m_rs2v;
   logic        m_use_pc, m_use_imm, m_branch, m_rtype, m_f75, m_rw, m_ld;
   logic [2:0]  m_funct3;
   logic [4:0]  m_rd;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
      .in_is_rtype(in_is_rtype), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
      .in_is_branch(in_is_branch), .in_is_load(in_is_load), .in_reg_write(in_reg_write),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_wen(exmem_wen), .memwb_wen(memwb_wen), .exmem_is_load(exmem_is_load),
      .exmem_result(exmem_result), .memwb_result(memwb_result),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
      .alu_select(alu_select), .alu_func7(alu_func7),
      .out_rd(out_rd), .out_reg_write(out_reg_write), .out_is_load(out_is_load)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] fwd_val(input logic [4:0] rs, input logic [31:0] rf);
      logic [31:0] v;
      v = rf;
      if (FWD && rs != 5'd0) begin
         if (exmem_wen && exmem_rd == rs && !exmem_is_load)
            v = exmem_result;
         else if (memwb_wen && memwb_rd == rs)
            v = memwb_result;
      end
      return v;
   endfunction

   function automatic bit load_hazard(input logic [4:0] rs);
      return FWD && rs != 5'd0 && exmem_wen && exmem_is_load && exmem_rd == rs;
   endfunction

   function automatic bit model_in_ready();
      return !m_bubble && (!m_valid || out_ready);
   endfunction

   task automatic model_reset();
      m_valid = 0; m_bubble = 0; m_zeroed = 1; m_hz1 = 0; m_hz2 = 0;
      m_pc = '0; m_imm = '0; m_rs1v = '0; m_rs2v = '0;
      m_use_pc = 0; m_use_imm = 0; m_branch = 0; m_rtype = 0; m_f75 = 0;
      m_rw = 0; m_ld = 0; m_funct3 = '0; m_rd = '0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      bit rdy;
      rdy = model_in_ready();
      if (flush) begin
         m_valid = 0;
         m_bubble = 0;
      end else if (m_bubble) begin
         if (m_hz1) m_rs1v = memwb_result;
         if (m_hz2) m_rs2v = memwb_result;
         m_bubble = 0;
         m_valid = 1;
      end else if (in_valid && rdy) begin
         m_zeroed = 0;
         m_pc = in_pc; m_imm = in_imm;
         m_rs1v = fwd_val(in_rs1, in_rs1_data);
         m_rs2v = fwd_val(in_rs2, in_rs2_data);
         m_use_pc = in_use_pc; m_use_imm = in_use_imm;
         m_branch = in_is_branch; m_rtype = in_is_rtype; m_f75 = in_funct7_5;
         m_funct3 = in_funct3; m_rd = in_rd; m_rw = in_reg_write; m_ld = in_is_load;
         m_hz1 = load_hazard(in_rs1);
         m_hz2 = load_hazard(in_rs2);
         m_bubble = m_hz1 || m_hz2;
         m_valid = !m_bubble;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic check_all();
      checkOutput("out_valid", out_valid, m_valid);
      if (m_valid || m_zeroed) begin
         checkOutput("alu_a", alu_a, m_use_pc ? m_pc : m_rs1v);
         checkOutput("alu_b", alu_b, m_use_imm ? m_imm : m_rs2v);
         checkOutput("store_data", store_data, m_rs2v);
         checkOutput("alu_select", alu_select, m_branch ? 3'b000 : m_funct3);
         checkOutput("alu_func7", alu_func7, m_branch ? 1'b1 : (m_rtype & m_f75));
         checkOutput("out_rd", out_rd, m_rd);
         checkOutput("out_reg_write", out_reg_write, m_rw);
         checkOutput("out_is_load", out_is_load, m_ld);
      end
   endtask

   // Called just after a falling edge with inputs set; returns at the next falling edge.
   task automatic applyStimulus();
      #1;
      checkOutput("in_ready", in_ready, model_in_ready());
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic clear_inputs();
      in_valid = 0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
      in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_funct3 = '0; in_funct7_5 = 0;
      in_is_rtype = 0; in_use_imm = 0; in_use_pc = 0; in_is_branch = 0; in_is_load = 0; in_reg_write = 0;
      exmem_rd = '0; memwb_rd = '0; exmem_wen = 0; memwb_wen = 0; exmem_is_load = 0;
      exmem_result = '0; memwb_result = '0; flush = 0; out_ready = 1;
   endtask

   task automatic randomize_inputs();
      in_valid = ($urandom_range(0, 3) != 0);
      in_pc = $urandom; in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
      in_rs1 = 5'($urandom_range(0, 3)); in_rs2 = 5'($urandom_range(0, 3)); in_rd = 5'($urandom);
      in_funct3 = 3'($urandom); in_funct7_5 = 1'($urandom);
      in_is_rtype = 1'($urandom); in_use_imm = 1'($urandom); in_use_pc = ($urandom_range(0, 3) == 0);
      in_is_branch = ($urandom_range(0, 3) == 0); in_is_load = 1'($urandom); in_reg_write = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
      exmem_wen = 1'($urandom); memwb_wen = 1'($urandom); exmem_is_load = ($urandom_range(0, 3) == 0);
      exmem_result = $urandom; memwb_result = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic do_reset();
      rst_n = 0;
      #1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic issue_load_use();
      clear_inputs();
      in_valid = 1; in_rs1 = 5'd5; in_rs1_data = 32'h99; in_rd = 5'd6; in_is_rtype = 1; in_reg_write = 1;
      exmem_rd = 5'd5; exmem_wen = 1; exmem_is_load = 1;
      applyStimulus();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      clear_inputs();
      model_reset();
      do_reset();
      #1;
      checkOutput("reset_in_ready", in_ready, 1'b1);
      check_all();

      // ADD x3,x1,x2 with x1 in EX/MEM
      clear_inputs();
      in_valid = 1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3; in_rs1_data = 32'd5; in_rs2_data = 32'd7;
      in_is_rtype = 1; in_reg_write = 1; exmem_rd = 5'd1; exmem_wen = 1; exmem_result = 32'd100;
      applyStimulus();
      checkOutput("add_a", alu_a, FWD ? 32'd100 : 32'd5);
      checkOutput("add_b", alu_b, 32'd7);
      checkOutput("add_sel", alu_select, 3'b000);
      checkOutput("add_f7", alu_func7, 1'b0);

      // x0 is never forwarded
      clear_inputs();
      in_valid = 1; in_rs1 = 5'd0; in_rs1_data = 32'd0; exmem_rd = 5'd0; exmem_wen = 1; exmem_result = 32'hDEAD;
      applyStimulus();
      checkOutput("x0_a", alu_a, 32'd0);

      // EX/MEM wins over MEM/WB
      clear_inputs();
      in_valid = 1; in_rs1 = 5'd4; in_rs1_data = 32'h33;
      exmem_rd = 5'd4; exmem_wen = 1; exmem_result = 32'h11;
      memwb_rd = 5'd4; memwb_wen = 1; memwb_result = 32'h22;
      applyStimulus();
      checkOutput("prio_a", alu_a, FWD ? 32'h11 : 32'h33);

      // Load-use: one bubble then the MEM/WB value
      issue_load_use();
      checkOutput("ld_bubble_valid", out_valid, FWD ? 1'b0 : 1'b1);
      clear_inputs();
      out_ready = 0; memwb_result = 32'h1234;
      #1;
      checkOutput("ld_in_ready", in_ready, 1'b0);
      applyStimulus();
      checkOutput("ld_valid", out_valid, 1'b1);
      checkOutput("ld_a", alu_a, FWD ? 32'h1234 : 32'h99);

      // BEQ forces subtract
      clear_inputs();
      in_valid = 1; in_is_branch = 1; in_funct3 = 3'b000; in_rs1 = 5'd7; in_rs2 = 5'd8;
      in_rs1_data = 32'd9; in_rs2_data = 32'd9;
      applyStimulus();
      applyStimulus();
      checkOutput("beq_sel", alu_select, 3'b000);
      checkOutput("beq_f7", alu_func7, 1'b1);

      // ADDI with bit30 set is still an add
      clear_inputs();
      in_valid = 1; in_use_imm = 1; in_imm = 32'hFFFF_FFFF; in_funct7_5 = 1; in_is_rtype = 0; in_funct3 = 3'b000;
      applyStimulus();
      checkOutput("addi_b", alu_b, 32'hFFFF_FFFF);
      checkOutput("addi_f7", alu_func7, 1'b0);

      // Backpressure for 3 cycles, then flush
      clear_inputs();
      in_valid = 1; in_pc = 32'h400; in_use_pc = 1; in_rd = 5'd9; in_funct3 = 3'b110;
      applyStimulus();
      for (int i = 0; i < 3; i++) begin
         clear_inputs();
         in_valid = 1; in_pc = 32'h800 + 32'(i); out_ready = 0;
         #1;
         checkOutput("bp_in_ready", in_ready, 1'b0);
         applyStimulus();
         checkOutput("bp_a", alu_a, 32'h400);
      end
      clear_inputs();
      out_ready = 0; flush = 1;
      applyStimulus();
      checkOutput("flush_valid", out_valid, 1'b0);

      // Asynchronous reset while stalled
      issue_load_use();
      clear_inputs();
      #2;
      do_reset();
      #1;
      checkOutput("rst_stall_valid", out_valid, 1'b0);
      checkOutput("rst_stall_a", alu_a, 32'd0);
      checkOutput("rst_stall_in_ready", in_ready, 1'b1);
      check_all();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         randomize_inputs();
         applyStimulus();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register of the Goldcrest RV32I core, sitting directly upstream of the ALU. It captures one decoded instruction per cycle under a valid/ready handshake, resolves operand hazards by forwarding from EX/MEM and MEM/WB, and inserts a one-cycle load-use bubble. It presents ALU-ready operands `A`/`B`, the 3-bit `select` (funct3) and the `func_7` add/sub control.

## Interface
- XLEN, 32, datapath width; the ALU fixes it at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid / in_ready  in/out  1  handshake from decode
- in_pc, in_rs1_data, in_rs2_data, in_imm  in  XLEN  decoded PC, register-file reads, sign-extended immediate
- in_rs1, in_rs2, in_rd  in  5  register addresses
- in_funct3  in  3  instruction funct3
- in_funct7_5  in  1  instruction bit 30
- in_is_rtype, in_use_imm, in_use_pc, in_is_branch, in_is_load, in_reg_write  in  1  decode class flags
- exmem_rd, memwb_rd  in  5  destinations of the later stages
- exmem_wen, memwb_wen, exmem_is_load  in  1  later-stage write enables and load flag
- exmem_result, memwb_result  in  XLEN  forwardable results
- flush  in  1  kill the held instruction (taken branch/jump)
- out_valid / out_ready  out/in  1  handshake to the ALU/EX stage
- alu_a, alu_b, store_data  out  XLEN  ALU operands and forwarded rs2 for stores
- alu_select  out  3  to ALU `select`
- alu_func7  out  1  to ALU `func_7`
- out_rd  out  5; out_reg_write, out_is_load  out  1  passed through

## Operation
- States: EMPTY, FULL, LOAD_STALL. Reset enters EMPTY.
- in_ready = (state==EMPTY) | (state==FULL & out_ready). It is never high in LOAD_STALL.
- Capture on in_valid & in_ready:
  - Store pc, imm, addresses and flags.
  - Store the forwarded rs1/rs2 values.
  - Next state is FULL, or LOAD_STALL on a load-use hazard.
- Forwarding for each source rsN:
  - If rsN != 0 & exmem_wen & exmem_rd == rsN & !exmem_is_load, take exmem_result.
  - Else if rsN != 0 & memwb_wen & memwb_rd == rsN, take memwb_result.
  - Else take the register-file value.
  - x0 is never forwarded.
- Load-use hazard: a captured rsN != 0 equals exmem_rd while exmem_wen & exmem_is_load.
  - In LOAD_STALL, out_valid = 0.
  - Next cycle, every hazarded source re-samples memwb_result; the others keep their value.
  - Then go to FULL.
- FULL & out_ready & !in_valid goes to EMPTY. FULL & out_ready & in_valid captures back-to-back.
- Operand mux:
  - alu_a = in_use_pc ? pc : rs1v.
  - alu_b = in_use_imm ? imm : rs2v.
  - store_data = rs2v.
- Control mapping:
  - in_is_branch: alu_select = 3'b000 and alu_func7 = 1 (subtract for flags). Compare ops 010/011 are not used for branches.
  - Otherwise: alu_select = funct3 and alu_func7 = in_is_rtype & funct7_5. So ADDI is never a subtract.
- flush: next state is EMPTY and out_valid drops next cycle, regardless of state. A flush in the same cycle as in_valid discards the new instruction and keeps in_ready as computed.

## Timing
- Latency: 1 cycle from capture to out_valid. A load-use case takes 2 cycles.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Outputs are registered and stable while out_valid & !out_ready.
- Reset (async, any state, mid-stall included):
  - state = EMPTY, out_valid = 0.
  - All data outputs, alu_select, alu_func7, out_rd, out_reg_write and out_is_load are 0.
- Simultaneous events, in priority order: rst_n, then flush, then the load-stall resolve, then capture.

## Configuration
- OPERAND_FWD_EN defined:
  - Forwarding and the load-use detection/bubble are as described above.
- OPERAND_FWD_EN undefined:
  - Operands come only from in_rs1_data/in_rs2_data.
  - LOAD_STALL is unreachable and the exmem_*/memwb_* inputs are ignored.
  - Hazard avoidance moves to software (NOP insertion).

## Test plan
- Reset mid-LOAD_STALL -> next cycle out_valid = 0, alu_a = 0, state EMPTY, in_ready = 1.
- ADD x3,x1,x2 with rs1_data = 5, rs2_data = 7, exmem_rd = 1, exmem_wen = 1, exmem_result = 100 -> alu_a = 100, alu_b = 7, alu_select = 000, alu_func7 = 0.
- x0 source with exmem_rd = 0, exmem_wen = 1, exmem_result = 0xDEAD -> operand equals the register-file value 0. Also: rs1 matching both exmem (0x11) and memwb (0x22) -> 0x11.
- Load-use hazard with exmem_is_load = 1, exmem_rd = rs1; memwb_result = 0x1234 next cycle -> one cycle of out_valid = 0 with in_ready = 0, then out_valid = 1 and alu_a = 0x1234.
- BEQ with funct3 = 000 -> alu_select = 000, alu_func7 = 1. ADDI with imm = -1 and bit30 set -> alu_b = 0xFFFFFFFF, alu_func7 = 0.
- out_ready held low for 3 cycles -> outputs unchanged and in_ready = 0. Then flush -> out_valid = 0 on the next cycle.
